// File: rtl/tile_seq_ctrl.sv
// Job/tile sequencer for an N x N systolic PE array: clear, skewed feed, drain, result handshake.
// Optional busy-cycle counter on perf_cycles when TILE_SEQ_CTRL_PERF_EN is defined.
module tile_seq_ctrl #(
  parameter int unsigned N          = 4,
  parameter int unsigned K_WIDTH    = 8,
  parameter int unsigned TILE_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [K_WIDTH-1:0]    k_len,
  input  logic [TILE_WIDTH-1:0] num_tiles,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  arr_rst_n,
  output logic [CNT_WIDTH-1:0]  feed_cnt,
  output logic [N-1:0]          row_valid,
  output logic [N-1:0]          col_valid,
  output logic [TILE_WIDTH-1:0] tile_idx,
  output logic                  res_valid
`ifdef TILE_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StResult, StDone} state_e;

  state_e                state_q, state_d;
  logic [K_WIDTH-1:0]    k_q, k_d;
  logic [TILE_WIDTH-1:0] tiles_q, tiles_d;
  logic [TILE_WIDTH-1:0] tile_idx_q, tile_idx_d;
  logic [CNT_WIDTH-1:0]  feed_cnt_q, feed_cnt_d;
  logic [N-1:0]          row_valid_q, row_valid_d;
  logic [N-1:0]          col_valid_q, col_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  arr_rst_n_q, arr_rst_n_d;
  logic                  res_valid_q, res_valid_d;

  logic [CNT_WIDTH-1:0]  k_ext, feed_last, drain_last;

  assign k_ext      = CNT_WIDTH'(k_q);
  assign feed_last  = k_ext + CNT_WIDTH'(N) - CNT_WIDTH'(2);
  assign drain_last = feed_last + CNT_WIDTH'(N);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    tiles_d    = tiles_q;
    tile_idx_d = tile_idx_q;
    feed_cnt_d = feed_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (k_len != '0 && num_tiles != '0) begin
            k_d        = k_len;
            tiles_d    = num_tiles;
            tile_idx_d = '0;
            state_d    = StClear;
          end else begin
            state_d = StDone;
          end
        end
      end
      StClear: begin
        feed_cnt_d = '0;
        state_d    = StFeed;
      end
      StFeed: begin
        feed_cnt_d = feed_cnt_q + CNT_WIDTH'(1);
        if (feed_cnt_q == feed_last) state_d = StDrain;
      end
      StDrain: begin
        feed_cnt_d = feed_cnt_q + CNT_WIDTH'(1);
        if (feed_cnt_q == drain_last) state_d = StResult;
      end
      StResult: begin
        if (res_ready) begin
          if (tile_idx_q == tiles_q - TILE_WIDTH'(1)) begin
            state_d = StDone;
          end else begin
            tile_idx_d = tile_idx_q + TILE_WIDTH'(1);
            state_d    = StClear;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every output is a plain flop.
  always_comb begin
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    arr_rst_n_d = (state_d != StClear);
    res_valid_d = (state_d == StResult);
    row_valid_d = '0;
    for (int i = 0; i < N; i++) begin
      row_valid_d[i] = (state_d == StFeed) && (feed_cnt_d >= CNT_WIDTH'(i)) &&
                       (feed_cnt_d < k_ext + CNT_WIDTH'(i));
    end
    col_valid_d = row_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      tiles_q     <= '0;
      tile_idx_q  <= '0;
      feed_cnt_q  <= '0;
      row_valid_q <= '0;
      col_valid_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arr_rst_n_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tiles_q     <= tiles_d;
      tile_idx_q  <= tile_idx_d;
      feed_cnt_q  <= feed_cnt_d;
      row_valid_q <= row_valid_d;
      col_valid_q <= col_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      arr_rst_n_q <= arr_rst_n_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign arr_rst_n = arr_rst_n_q;
  assign feed_cnt  = feed_cnt_q;
  assign row_valid = row_valid_q;
  assign col_valid = col_valid_q;
  assign tile_idx  = tile_idx_q;
  assign res_valid = res_valid_q;

`ifdef TILE_SEQ_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == StIdle && start) begin
      perf_d = '0;
    end else if (busy_q && perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Directed bench for tile_seq_ctrl (N=4); perf_cycles checked when TILE_SEQ_CTRL_PERF_EN is defined.
module tb_tile_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] k_len;
  logic [7:0] num_tiles;
  logic       res_ready;
  logic       busy;
  logic       done;
  logic       arr_rst_n;
  logic [9:0] feed_cnt;
  logic [3:0] row_valid;
  logic [3:0] col_valid;
  logic [7:0] tile_idx;
  logic       res_valid;
`ifdef TILE_SEQ_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int n_vec;
  int n_err;

  tile_seq_ctrl #(
    .N          (4),
    .K_WIDTH    (8),
    .TILE_WIDTH (8),
    .CNT_WIDTH  (10)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .num_tiles  (num_tiles),
    .res_ready  (res_ready),
    .busy       (busy),
    .done       (done),
    .arr_rst_n  (arr_rst_n),
    .feed_cnt   (feed_cnt),
    .row_valid  (row_valid),
    .col_valid  (col_valid),
    .tile_idx   (tile_idx),
    .res_valid  (res_valid)
`ifdef TILE_SEQ_CTRL_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] k, input logic [7:0] tiles);
    k_len     = k;
    num_tiles = tiles;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_arst"}, 32'(arr_rst_n), 32'd0);
    check_eq({tag, "_fcnt"}, 32'(feed_cnt), 32'd0);
    check_eq({tag, "_row"}, 32'(row_valid), 32'd0);
    check_eq({tag, "_col"}, 32'(col_valid), 32'd0);
    check_eq({tag, "_tile"}, 32'(tile_idx), 32'd0);
    check_eq({tag, "_rv"}, 32'(res_valid), 32'd0);
  endtask

  // Hand trace for K=4, N=4: t = c-2 during FEED (cycles 2..8).
  function automatic logic [3:0] exp_row(input int c);
    case (c)
      2:       return 4'b0001;
      3:       return 4'b0011;
      4:       return 4'b0111;
      5:       return 4'b1111;
      6:       return 4'b1110;
      7:       return 4'b1100;
      8:       return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // K=4, N=4, one tile, res_ready high; leaves the bench in cycle 15 (IDLE).
  task automatic run_single_tile(input string tag);
    res_ready = 1'b1;
    start_job(8'd4, 8'd1);
    for (int c = 1; c <= 15; c++) begin
      check_eq($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= 14));
      check_eq($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(c == 14));
      check_eq($sformatf("%s_arst_c%0d", tag, c), 32'(arr_rst_n), 32'(c != 1));
      check_eq($sformatf("%s_rv_c%0d", tag, c), 32'(res_valid), 32'(c == 13));
      check_eq($sformatf("%s_row_c%0d", tag, c), 32'(row_valid), 32'(exp_row(c)));
      check_eq($sformatf("%s_col_c%0d", tag, c), 32'(col_valid), 32'(exp_row(c)));
      if (c >= 2 && c <= 12) begin
        check_eq($sformatf("%s_fcnt_c%0d", tag, c), 32'(feed_cnt), 32'(c - 2));
      end
      if (c <= 14) check_eq($sformatf("%s_tile_c%0d", tag, c), 32'(tile_idx), 32'd0);
      if (c < 15) tick();
    end
  endtask

  initial begin
    int first_rv[3];
    int t1_last, hold, hold_bad, n_clr, done_cnt, done_c, busy40;
    int rv_seen, found;

    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    num_tiles = '0;
    res_ready = 1'b0;

    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();
    check_eq("rst_release_arst", 32'(arr_rst_n), 32'd1);
    check_eq("rst_release_busy", 32'(busy), 32'd0);

    // Scenario 1: single tile.
    run_single_tile("s1");
`ifdef TILE_SEQ_CTRL_PERF_EN
    check_eq("s1_perf", perf_cycles, 32'd14);
    repeat (2) tick();
    check_eq("s1_perf_hold", perf_cycles, 32'd14);
`endif

    // Scenario 2: 3 tiles, K=2, res_ready low for 5 cycles on tile 1, stray starts ignored.
    first_rv = '{0, 0, 0};
    t1_last  = 0;
    hold     = 0;
    hold_bad = 0;
    n_clr    = 0;
    done_cnt = 0;
    done_c   = 0;
    busy40   = 1;
    res_ready = 1'b1;
    start_job(8'd2, 8'd3);
`ifdef TILE_SEQ_CTRL_PERF_EN
    check_eq("s2_perf_cleared", perf_cycles, 32'd0);
`endif
    for (int c = 1; c <= 40; c++) begin
      if (res_valid) begin
        if (tile_idx < 8'd3 && first_rv[tile_idx] == 0) first_rv[tile_idx] = c;
        if (tile_idx == 8'd1) begin
          hold++;
          t1_last = c;
        end
        if (row_valid != '0 || col_valid != '0) hold_bad++;
      end
      if (!arr_rst_n) n_clr++;
      if (done) begin
        done_cnt++;
        done_c = c;
      end
      if (c == 40) begin
        busy40 = int'(busy);
        break;
      end
      res_ready = !(res_valid && tile_idx == 8'd1 && hold <= 5);
      start     = (c == 4) || (c == 39);
      if (c == 3) begin
        k_len     = 8'd7;
        num_tiles = 8'd9;
      end
      tick();
    end
    start = 1'b0;
    check_eq("s2_t0_result", 32'(first_rv[0]), 32'd11);
    check_eq("s2_t1_result", 32'(first_rv[1]), 32'd22);
    check_eq("s2_t1_accept", 32'(t1_last), 32'd27);
    check_eq("s2_t1_len", 32'(hold), 32'd6);
    check_eq("s2_t2_result", 32'(first_rv[2]), 32'd38);
    check_eq("s2_masks_in_result", 32'(hold_bad), 32'd0);
    check_eq("s2_clear_cycles", 32'(n_clr), 32'd3);
    check_eq("s2_done_count", 32'(done_cnt), 32'd1);
    check_eq("s2_done_cycle", 32'(done_c), 32'd39);
    check_eq("s2_start_in_done_ignored", 32'(busy40), 32'd0);
`ifdef TILE_SEQ_CTRL_PERF_EN
    check_eq("s2_perf", perf_cycles, 32'd39);
`endif

    // Scenario 3: empty jobs, started from the IDLE cycle right after DONE.
    start_job(8'd5, 8'd0);
    check_eq("s3a_done", 32'(done), 32'd1);
    check_eq("s3a_busy", 32'(busy), 32'd1);
    check_eq("s3a_arst", 32'(arr_rst_n), 32'd1);
    check_eq("s3a_rv", 32'(res_valid), 32'd0);
    tick();
    check_eq("s3a_done_end", 32'(done), 32'd0);
    check_eq("s3a_idle", 32'(busy), 32'd0);
    start_job(8'd0, 8'd2);
    check_eq("s3b_done", 32'(done), 32'd1);
    check_eq("s3b_arst", 32'(arr_rst_n), 32'd1);
    check_eq("s3b_rv", 32'(res_valid), 32'd0);
    tick();
    check_eq("s3b_idle", 32'(busy), 32'd0);

    // Scenario 4: reset in the middle of FEED, then a fresh tile.
    res_ready = 1'b1;
    start_job(8'd4, 8'd1);
    found = 0;
    for (int c = 0; c < 12; c++) begin
      if (feed_cnt == 10'd3 && row_valid == 4'b1111) begin
        found = 1;
        break;
      end
      tick();
    end
    check_eq("s4_reach_t3", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("s4_mid");
`ifdef TILE_SEQ_CTRL_PERF_EN
    check_eq("s4_perf_rst", perf_cycles, 32'd0);
`endif
    rst = 1'b0;
    tick();
    check_eq("s4_arst_back", 32'(arr_rst_n), 32'd1);
    rv_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || res_valid || busy) rv_seen++;
      tick();
    end
    check_eq("s4_no_resume", 32'(rv_seen), 32'd0);
    run_single_tile("s4_rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
